// File: rtl/psram_cmd_sched.sv
// PSRAM command scheduler: round-robin grant over NREQ requesters,
// page- and chunk-limited command splitting, one command outstanding.
module psram_cmd_sched #(
    parameter int NREQ       = 3,
    parameter int AW         = 32,
    parameter int LENW       = 8,
    parameter int PAGE_BYTES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [LENW-1:0]      max_chunk_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      wr_i,
    input  logic [NREQ*AW-1:0]   addr_i,
    input  logic [NREQ*LENW-1:0] len_i,
    output logic [NREQ-1:0]      ack_o,
    output logic [NREQ-1:0]      grant_o,
    output logic                 busy_o,
    output logic                 cmd_valid_o,
    input  logic                 cmd_ready_i,
    output logic                 cmd_wr_o,
    output logic [AW-1:0]        cmd_addr_o,
    output logic [LENW-1:0]      cmd_len_o,
    input  logic                 done_i
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = LENW + 1;
    localparam int PB = $clog2(PAGE_BYTES);
    localparam logic [PB:0] PAGE_L = (PB+1)'(PAGE_BYTES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t          state_q;
    logic [IW-1:0]   rr_q, win_q;
    logic [AW-1:0]   addr_q;
    logic [CW-1:0]   rem_q, chunk_q;
    logic            wr_q;
    logic [NREQ-1:0] ack_q, grant_q;
    logic            busy_q, cmd_valid_q, cmd_wr_q;
    logic [AW-1:0]   cmd_addr_q;
    logic [LENW-1:0] cmd_len_q;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [AW-1:0]   sel_addr, addr_d;
    logic [LENW-1:0] sel_len;
    logic            sel_wr;
    logic [CW-1:0]   rem_d, chunk_d;

    // Bytes for the next command: bounded by remaining, page end and cap.
    function automatic logic [CW-1:0] chunk_f(
        input logic [AW-1:0]   a,
        input logic [CW-1:0]   r,
        input logic [LENW-1:0] m
    );
        logic [PB:0]   prem;
        logic [CW-1:0] c;
        prem = PAGE_L - {1'b0, a[PB-1:0]};
        c    = r;
        if (32'(prem) < 32'(c))
            c = CW'(prem);
        if (m != '0 && 32'(m) < 32'(c))
            c = {1'b0, m};
        return c;
    endfunction

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_found && req_i[(int'(rr_q) + k) % NREQ]) begin
                pick_found = 1'b1;
                pick_idx   = IW'((int'(rr_q) + k) % NREQ);
            end
        end
        sel_addr = addr_i[int'(pick_idx)*AW +: AW];
        sel_len  = len_i[int'(pick_idx)*LENW +: LENW];
        sel_wr   = wr_i[pick_idx];
        if (state_q == IDLE) begin
            addr_d = sel_addr;
            rem_d  = {1'b0, sel_len} + CW'(1);
        end else begin
            addr_d = addr_q + AW'(chunk_q);
            rem_d  = rem_q - chunk_q;
        end
        chunk_d = chunk_f(addr_d, rem_d, max_chunk_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            win_q       <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            chunk_q     <= '0;
            wr_q        <= 1'b0;
            ack_q       <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enable_i && pick_found) begin
                        state_q     <= ISSUE;
                        win_q       <= pick_idx;
                        addr_q      <= addr_d;
                        rem_q       <= rem_d;
                        chunk_q     <= chunk_d;
                        wr_q        <= sel_wr;
                        grant_q     <= NREQ'(1) << pick_idx;
                        busy_q      <= 1'b1;
                        cmd_valid_q <= 1'b1;
                        cmd_wr_q    <= sel_wr;
                        cmd_addr_q  <= addr_d;
                        cmd_len_q   <= LENW'(chunk_d - CW'(1));
                    end
                end
                ISSUE: begin
                    if (cmd_ready_i) begin
                        state_q     <= WAIT;
                        cmd_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (done_i) begin
                        addr_q <= addr_d;
                        rem_q  <= rem_d;
                        if (rem_d == '0) begin
                            state_q      <= ACK;
                            ack_q[win_q] <= 1'b1;
                        end else begin
                            state_q     <= ISSUE;
                            chunk_q     <= chunk_d;
                            cmd_valid_q <= 1'b1;
                            cmd_wr_q    <= wr_q;
                            cmd_addr_q  <= addr_d;
                            cmd_len_q   <= LENW'(chunk_d - CW'(1));
                        end
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    ack_q   <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    rr_q    <= (win_q == IW'(NREQ-1)) ? '0 : win_q + 1'b1;
                end
            endcase
        end
    end

    assign ack_o       = ack_q;
    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_wr_o    = cmd_wr_q;
    assign cmd_addr_o  = cmd_addr_q;
    assign cmd_len_o   = cmd_len_q;

endmodule

// File: tb/tb_psram_cmd_sched.sv
// Directed bench for psram_cmd_sched: splitting, round-robin,
// backpressure, enable gating and mid-request reset.
module tb_psram_cmd_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  max_chunk;
    logic [2:0]  req, wr;
    logic [95:0] addr;
    logic [23:0] len;
    logic [2:0]  ack, grant;
    logic        busy, cmd_valid, cmd_ready, cmd_wr, done;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;

    int n_cmp = 0;
    int n_err = 0;

    psram_cmd_sched dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .max_chunk_i (max_chunk),
        .req_i       (req),
        .wr_i        (wr),
        .addr_i      (addr),
        .len_i       (len),
        .ack_o       (ack),
        .grant_o     (grant),
        .busy_o      (busy),
        .cmd_valid_o (cmd_valid),
        .cmd_ready_i (cmd_ready),
        .cmd_wr_o    (cmd_wr),
        .cmd_addr_o  (cmd_addr),
        .cmd_len_o   (cmd_len),
        .done_i      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [7:0] l);
        addr[i*32 +: 32] = a;
        len[i*8 +: 8]    = l;
    endtask

    // Accept one command after checking it, then complete it.
    task automatic issue(input string tag, input logic [31:0] ea,
                         input logic [7:0] el, input logic ew);
        int n = 0;
        while (!cmd_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, cmd_valid, 1);
        chk({tag, "_addr"}, cmd_addr, ea);
        chk({tag, "_len"}, cmd_len, el);
        chk({tag, "_wr"}, cmd_wr, ew);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk({tag, "_vlow"}, cmd_valid, 0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic finish_ack(input string tag, input logic [2:0] who);
        chk({tag, "_ack"}, ack, who);
        chk({tag, "_grant_ack"}, grant, who);
        req = req & ~who;
        tick();
        chk({tag, "_ack_low"}, ack, 0);
        chk({tag, "_grant_idle"}, grant, 0);
        chk({tag, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        max_chunk = 8'd0;
        req       = 3'b000;
        wr        = 3'b010;
        addr      = '0;
        len       = '0;
        cmd_ready = 1'b0;
        done      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ack", ack, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_cmd", {cmd_wr, cmd_addr, cmd_len}, 0);

        // single read, no split
        enable = 1'b1;
        set_req(0, 32'h100, 8'd31);
        req = 3'b001;
        tick();
        chk("t1_grant", grant, 3'b001);
        chk("t1_busy", busy, 1);
        issue("t1_c0", 32'h100, 8'd31, 1'b0);
        finish_ack("t1", 3'b001);

        // page split, write on requester 1
        set_req(1, 32'h3F0, 8'd63);
        req = 3'b010;
        tick();
        chk("t2_grant", grant, 3'b010);
        issue("t2_c0", 32'h3F0, 8'd15, 1'b1);
        chk("t2_noack", ack, 0);
        issue("t2_c1", 32'h400, 8'd47, 1'b1);
        finish_ack("t2", 3'b010);

        // chunk limit
        max_chunk = 8'd32;
        set_req(2, 32'h0, 8'd99);
        req = 3'b100;
        tick();
        chk("t3_grant", grant, 3'b100);
        issue("t3_c0", 32'h00, 8'd31, 1'b0);
        issue("t3_c1", 32'h20, 8'd31, 1'b0);
        issue("t3_c2", 32'h40, 8'd31, 1'b0);
        chk("t3_noack", ack, 0);
        issue("t3_c3", 32'h60, 8'd3, 1'b0);
        finish_ack("t3", 3'b100);
        max_chunk = 8'd0;

        // round-robin from rr=0
        set_req(0, 32'h10, 8'd7);
        set_req(1, 32'h20, 8'd7);
        set_req(2, 32'h30, 8'd7);
        req = 3'b111;
        tick();
        chk("rr0_g0", grant, 3'b001);
        issue("rr0_c0", 32'h10, 8'd7, 1'b0);
        finish_ack("rr0_a0", 3'b001);
        tick();
        chk("rr0_g1", grant, 3'b010);
        issue("rr0_c1", 32'h20, 8'd7, 1'b1);
        finish_ack("rr0_a1", 3'b010);
        tick();
        chk("rr0_g2", grant, 3'b100);
        issue("rr0_c2", 32'h30, 8'd7, 1'b0);
        finish_ack("rr0_a2", 3'b100);

        // move rr to 1, then all three again
        req = 3'b001;
        tick();
        chk("rr1_pre", grant, 3'b001);
        issue("rr1_pre_c", 32'h10, 8'd7, 1'b0);
        finish_ack("rr1_pre", 3'b001);
        req = 3'b111;
        tick();
        chk("rr1_g1", grant, 3'b010);
        issue("rr1_c1", 32'h20, 8'd7, 1'b1);
        finish_ack("rr1_a1", 3'b010);
        tick();
        chk("rr1_g2", grant, 3'b100);
        issue("rr1_c2", 32'h30, 8'd7, 1'b0);
        finish_ack("rr1_a2", 3'b100);
        tick();
        chk("rr1_g0", grant, 3'b001);
        issue("rr1_c0", 32'h10, 8'd7, 1'b0);
        finish_ack("rr1_a0", 3'b001);

        // backpressure, spurious done, input changes after grant
        set_req(0, 32'h500, 8'd15);
        req = 3'b001;
        tick();
        chk("bp_grant", grant, 3'b001);
        set_req(0, 32'hFFF, 8'd0);
        for (int i = 0; i < 5; i++) begin
            done = (i == 2);
            tick();
            chk("bp_valid", cmd_valid, 1);
            chk("bp_cmd", {cmd_wr, cmd_addr, cmd_len}, {1'b0, 32'h500, 8'd15});
        end
        done   = 1'b0;
        enable = 1'b0;
        req    = 3'b011;
        issue("bp_c0", 32'h500, 8'd15, 1'b0);
        finish_ack("bp", 3'b001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_nogrant", grant, 0);
            chk("en_nobusy", busy, 0);
        end
        enable = 1'b1;
        tick();
        chk("en_grant", grant, 3'b010);
        issue("en_c0", 32'h20, 8'd7, 1'b1);
        finish_ack("en", 3'b010);

        // reset in WAIT
        set_req(0, 32'h10, 8'd7);
        req = 3'b001;
        tick();
        chk("rw_grant", grant, 3'b001);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("rw_wait", cmd_valid, 0);
        rst = 1'b1;
        req = 3'b000;
        tick();
        rst = 1'b0;
        chk("rw_ack", ack, 0);
        chk("rw_grant0", grant, 0);
        chk("rw_busy", busy, 0);
        chk("rw_valid", cmd_valid, 0);
        chk("rw_cmd", {cmd_wr, cmd_addr, cmd_len}, 0);
        tick();
        chk("rw_noack", ack, 0);
        req = 3'b110;
        tick();
        chk("rw_rr0", grant, 3'b010);
        issue("rw_c1", 32'h20, 8'd7, 1'b1);
        finish_ack("rw_a1", 3'b010);
        tick();
        chk("rw_g2", grant, 3'b100);
        issue("rw_c2", 32'h30, 8'd7, 1'b0);
        finish_ack("rw_a2", 3'b100);

        // address wrap at 2^AW
        set_req(2, 32'hFFFF_FFF8, 8'd15);
        req = 3'b100;
        tick();
        chk("wrap_grant", grant, 3'b100);
        issue("wrap_c0", 32'hFFFF_FFF8, 8'd7, 1'b0);
        issue("wrap_c1", 32'h0, 8'd7, 1'b0);
        finish_ack("wrap", 3'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
